// File: rtl/pipeline_pkg.sv
// Shared constants for the RV32 pipeline: datapath widths, ALU opcodes, forward selects.
package pipeline_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned FWD_W = 2;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

    localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational RV32 ALU: add/sub/and/or/slt, unused opcodes yield zero.
module alu
    import pipeline_pkg::*;
(
    input  logic [XLEN-1:0]  A,
    input  logic [XLEN-1:0]  B,
    input  logic [ALU_W-1:0] ALUControl,
    output logic [XLEN-1:0]  Result,
    output logic             Zero
);

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = XLEN'($signed(A) < $signed(B));
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, BEQ resolution and the EX/MEM pipeline register.
module execute_cycle
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteE,
    input  logic              ALUSrcE,
    input  logic              MemWriteE,
    input  logic              ResultSrcE,
    input  logic              BranchE,
    input  logic [ALU_W-1:0]  ALUControlE,
    input  logic [XLEN-1:0]   RD1_E,
    input  logic [XLEN-1:0]   RD2_E,
    input  logic [XLEN-1:0]   Imm_Ext_E,
    input  logic [REG_W-1:0]  RD_E,
    input  logic [XLEN-1:0]   PCE,
    input  logic [XLEN-1:0]   PCPlus4E,
    input  logic [XLEN-1:0]   ResultW,
    input  logic [FWD_W-1:0]  ForwardA_E,
    input  logic [FWD_W-1:0]  ForwardB_E,
    output logic              PCSrcE,
    output logic [XLEN-1:0]   PCTargetE,
    output logic              RegWriteM,
    output logic              MemWriteM,
    output logic              ResultSrcM,
    output logic [REG_W-1:0]  RD_M,
    output logic [XLEN-1:0]   PCPlus4M,
    output logic [XLEN-1:0]   WriteDataM,
    output logic [XLEN-1:0]   ALU_ResultM
);

    logic [XLEN-1:0]  src_a;
    logic [XLEN-1:0]  src_b_fwd;
    logic [XLEN-1:0]  src_b;
    logic [XLEN-1:0]  alu_result;
    logic             alu_zero;

    logic             reg_write_q;
    logic             mem_write_q;
    logic             result_src_q;
    logic [REG_W-1:0] rd_q;
    logic [XLEN-1:0]  pc_plus4_q;
    logic [XLEN-1:0]  write_data_q;
    logic [XLEN-1:0]  alu_result_q;

    // Forwarding from MEM uses the flop output, so there is no loop through the ALU.
    always_comb begin
        src_a = RD1_E;
        case (ForwardA_E)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = alu_result_q;
            default: src_a = RD1_E;
        endcase

        src_b_fwd = RD2_E;
        case (ForwardB_E)
            FWD_WB:  src_b_fwd = ResultW;
            FWD_MEM: src_b_fwd = alu_result_q;
            default: src_b_fwd = RD2_E;
        endcase
    end

    assign src_b = ALUSrcE ? Imm_Ext_E : src_b_fwd;

    alu u_alu (
        .A          (src_a),
        .B          (src_b),
        .ALUControl (ALUControlE),
        .Result     (alu_result),
        .Zero       (alu_zero)
    );

    assign PCSrcE    = alu_zero & BranchE;
    assign PCTargetE = PCE + Imm_Ext_E;

    // EX/MEM register loads every cycle; store data is the forwarded RD2, never the immediate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            write_data_q <= '0;
            alu_result_q <= '0;
        end else begin
            reg_write_q  <= RegWriteE;
            mem_write_q  <= MemWriteE;
            result_src_q <= ResultSrcE;
            rd_q         <= RD_E;
            pc_plus4_q   <= PCPlus4E;
            write_data_q <= src_b_fwd;
            alu_result_q <= alu_result;
        end
    end

    assign RegWriteM   = reg_write_q;
    assign MemWriteM   = mem_write_q;
    assign ResultSrcM  = result_src_q;
    assign RD_M        = rd_q;
    assign PCPlus4M    = pc_plus4_q;
    assign WriteDataM  = write_data_q;
    assign ALU_ResultM = alu_result_q;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: directed plan cases plus random traffic against a reference model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, alusrc, mw, rs, br;
        logic [2:0]  op;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rd;
        logic [31:0] pc, pc4, resw;
        logic [1:0]  fa, fb;
    } stim_t;

    typedef struct packed {
        logic        rw, mw, rs;
        logic [4:0]  rd;
        logic [31:0] pc4, wd, alu;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_mem;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf,
                                            input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'b01) return wb;
        if (sel == 2'b10) return mem;
        return rf;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rw = 1'($urandom); s.alusrc = 1'($urandom); s.mw = 1'($urandom);
        s.rs = 1'($urandom); s.br = 1'($urandom);
        s.op = 3'($urandom_range(0, 7));
        s.rd1 = $urandom;
        s.rd2 = ($urandom_range(0, 3) == 0) ? s.rd1 : $urandom;
        s.imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
        s.rd = 5'($urandom); s.pc = $urandom; s.pc4 = $urandom; s.resw = $urandom;
        s.fa = 2'($urandom); s.fb = 2'($urandom);
        return s;
    endfunction

    task automatic drive_inputs(input stim_t s);
        RegWriteE = s.rw; ALUSrcE = s.alusrc; MemWriteE = s.mw; ResultSrcE = s.rs; BranchE = s.br;
        ALUControlE = s.op; RD1_E = s.rd1; RD2_E = s.rd2; Imm_Ext_E = s.imm; RD_E = s.rd;
        PCE = s.pc; PCPlus4E = s.pc4; ResultW = s.resw; ForwardA_E = s.fa; ForwardB_E = s.fb;
    endtask

    // Drive one instruction, check the same-cycle branch outputs, queue the EX/MEM response.
    task automatic apply(input stim_t s);
        logic [31:0] a, bf, res;
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        drive_inputs(s);
        #1;
        a   = ref_fwd(s.fa, s.rd1, s.resw, model_mem);
        bf  = ref_fwd(s.fb, s.rd2, s.resw, model_mem);
        res = ref_alu(s.op, a, s.alusrc ? s.imm : bf);
        check("PCSrcE", 32'(PCSrcE), 32'(s.br && (res == 32'd0)));
        check("PCTargetE", PCTargetE, s.pc + s.imm);
        e.rw = s.rw; e.mw = s.mw; e.rs = s.rs; e.rd = s.rd;
        e.pc4 = s.pc4; e.wd = bf; e.alu = res;
        sb_q.push_back(e);
        model_mem = res;
    endtask

    task automatic expect_alu(input string name, input logic [31:0] v);
        @(posedge clk);
        #2;
        check(name, ALU_ResultM, v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " RegWriteM"}, 32'(RegWriteM), 32'd0);
        check({tag, " MemWriteM"}, 32'(MemWriteM), 32'd0);
        check({tag, " ResultSrcM"}, 32'(ResultSrcM), 32'd0);
        check({tag, " RD_M"}, 32'(RD_M), 32'd0);
        check({tag, " PCPlus4M"}, PCPlus4M, 32'd0);
        check({tag, " WriteDataM"}, WriteDataM, 32'd0);
        check({tag, " ALU_ResultM"}, ALU_ResultM, 32'd0);
    endtask

    // Asynchronous reset mid-stream: outputs clear at once and stay clear across an edge.
    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        drive_inputs(rand_stim());
        #1;
        check_all_zero("async_rst");
        sb_q.delete();
        model_mem = 32'd0;
        @(posedge clk);
        #1;
        check_all_zero("held_rst");
    endtask

    // Monitor: every edge out of reset must retire exactly the oldest queued instruction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("RegWriteM", 32'(RegWriteM), 32'(e.rw));
                check("MemWriteM", 32'(MemWriteM), 32'(e.mw));
                check("ResultSrcM", 32'(ResultSrcM), 32'(e.rs));
                check("RD_M", 32'(RD_M), 32'(e.rd));
                check("PCPlus4M", PCPlus4M, e.pc4);
                check("WriteDataM", WriteDataM, e.wd);
                check("ALU_ResultM", ALU_ResultM, e.alu);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        model_mem = 32'd0;
        rst = 1'b0;
        drive_inputs(rand_stim());
        #3 check_all_zero("reset");
        #6 check_all_zero("reset_edge");

        // ADD then SUB
        s = blank(); s.rw = 1; s.rd1 = 5; s.rd2 = 3; s.rd = 1; s.pc4 = 4;
        apply(s); expect_alu("add", 32'd8);
        s.op = 3'b001; s.rd1 = 8; apply(s); expect_alu("sub", 32'd5);

        // Load address, then store with forwarded RD2 as data
        s = blank(); s.rw = 1; s.alusrc = 1; s.rs = 1; s.rd1 = 16; s.imm = 4; s.rd = 2;
        apply(s); expect_alu("load_addr", 32'h14);
        s = blank(); s.mw = 1; s.alusrc = 1; s.rd1 = 20; s.rd2 = 32'hAABBCCDD; s.imm = 8;
        apply(s); expect_alu("store_addr", 32'h1C);

        // BEQ taken then not taken; target fixed
        s = blank(); s.op = 3'b001; s.br = 1; s.rd1 = 100; s.rd2 = 100; s.pc = 200; s.imm = 16;
        apply(s);
        check("beq_taken", 32'(PCSrcE), 32'd1);
        s.rd2 = 101; apply(s);
        check("beq_not_taken", 32'(PCSrcE), 32'd0);
        check("beq_target", PCTargetE, 32'd216);

        // Forwarding from WB, then from the EX/MEM register
        s = blank(); s.fa = 2'b01; s.resw = 32'h12345678; s.rd2 = 1;
        apply(s); expect_alu("fwd_wb", 32'h12345679);
        s = blank(); s.fb = 2'b10; s.rd1 = 2;
        apply(s); expect_alu("fwd_mem", 32'h1234567B);

        // Logic ops, SLT, unused opcode
        s = blank(); s.op = 3'b010; s.rd1 = 32'hF0F0F0F0; s.rd2 = 32'h0FF00FF0;
        apply(s); expect_alu("and", 32'h00F000F0);
        s.op = 3'b011; apply(s); expect_alu("or", 32'hFFF0FFF0);
        s = blank(); s.op = 3'b101; s.rd1 = 32'hFFFFFFFF; s.rd2 = 1;
        apply(s); expect_alu("slt", 32'd1);
        s = blank(); s.op = 3'b111; s.br = 1; s.rd1 = 7; s.rd2 = 9;
        apply(s);
        check("unused_zero", 32'(PCSrcE), 32'd1);
        expect_alu("unused_op", 32'd0);

        for (int i = 0; i < 300; i++) begin
            if (i == 150) mid_reset();
            apply(rand_stim());
        end

        @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute (EX) stage of a 5-stage RV32 in-order pipeline.
- Applies forwarding muxes to the ID/EX register operands, selects the register or immediate operand, and runs the ALU.
- Resolves branches: branch decision and target are combinational back to Fetch.
- Registers the results and control bits into the EX/MEM pipeline register feeding the Memory stage.

Parameters:
- None. Data path is fixed at 32 bits, register index at 5 bits, ALU control at 3 bits.

Ports:
- clk  in  1  pipeline clock; rising-edge active
- rst  in  1  asynchronous, active-low reset (0 = reset)
- RegWriteE  in  1  register-file write enable for this instruction
- ALUSrcE  in  1  ALU operand B select: 0 = forwarded RD2, 1 = Imm_Ext_E
- MemWriteE  in  1  data-memory write enable
- ResultSrcE  in  1  writeback select: 0 = ALU, 1 = memory
- BranchE  in  1  instruction is a BEQ
- ALUControlE  in  3  ALU operation code
- RD1_E  in  32  register source 1 value
- RD2_E  in  32  register source 2 value
- Imm_Ext_E  in  32  sign-extended immediate
- RD_E  in  5  destination register index
- PCE  in  32  PC of this instruction
- PCPlus4E  in  32  PC+4 of this instruction
- ResultW  in  32  writeback-stage result, used for forwarding
- ForwardA_E  in  2  forward select for operand A
- ForwardB_E  in  2  forward select for operand B
- PCSrcE  out  1  branch taken (combinational)
- PCTargetE  out  32  branch target (combinational)
- RegWriteM  out  1  registered RegWriteE
- MemWriteM  out  1  registered MemWriteE
- ResultSrcM  out  1  registered ResultSrcE
- RD_M  out  5  registered RD_E
- PCPlus4M  out  32  registered PCPlus4E
- WriteDataM  out  32  registered store data (forwarded operand B)
- ALU_ResultM  out  32  registered ALU result

Behaviour:
- Forward mux A over ForwardA_E:
  - 00 → RD1_E
  - 01 → ResultW
  - 10 → ALU_ResultM (current EX/MEM register output)
  - 11 → RD1_E
- Forward mux B: same encoding over ForwardB_E, default input RD2_E. Its output is SrcB_fwd.
- Operand B selection: SrcB = ALUSrcE ? Imm_Ext_E : SrcB_fwd.
- ALU, combinational, all arithmetic modulo 2^32, no overflow trap:
  - 000 add
  - 001 sub (A − B)
  - 010 bitwise AND
  - 011 bitwise OR
  - 101 SLT (signed A < B → 1, else 0)
  - 100, 110, 111 → result 0
- Zero = (ALU result == 0).
- Branch resolution, combinational, same cycle:
  - PCSrcE = Zero & BranchE.
  - PCTargetE = PCE + Imm_Ext_E, always computed regardless of BranchE.
- EX/MEM register:
  - On each rising clk edge with rst=1, the register captures RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E, SrcB_fwd (→ WriteDataM) and the ALU result (→ ALU_ResultM).
  - Latency is exactly 1 cycle. There is no stall or flush input; the register loads every cycle.
  - The store-data path is the forwarded RD2, never the immediate.
- Reset:
  - rst=0 immediately and asynchronously clears every registered output to 0: RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM.
  - Reset asserted mid-operation discards the in-flight instruction.
  - PCSrcE and PCTargetE stay combinational and are unaffected by reset.
- Forwarding from ALU_ResultM uses the pre-edge register value. No combinational loop exists because the path goes through the flop.
- BranchE has no effect on the registered outputs; control bits pass through unchanged.

Decomposition:
- Shared package pipeline_pkg holds:
  - ALU opcode constants: ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=101.
  - Forward select constants: FWD_RF=00, FWD_WB=01, FWD_MEM=10.
- One sub-module, alu:
  - Inputs: A, B, ALUControl.
  - Outputs: Result, Zero.
- Forward muxes, adder and pipeline register stay in execute_cycle.

Test Plan:
- Reset: hold rst=0 for 10 ns with random inputs → all M outputs 0; release → first edge loads inputs.
- ADD:
  - Stimulus: RegWriteE=1, ALUSrcE=0, op=000, RD1=5, RD2=3, RD_E=1, PCPlus4E=4.
  - Response after the next edge: ALU_ResultM=8, RegWriteM=1, RD_M=1, PCPlus4M=4.
  - Then op=001, RD1=8, RD2=3 → ALU_ResultM=5.
- Load/store address:
  - ALUSrcE=1, RD1=16, Imm=4 → ALU_ResultM=0x14, ResultSrcM=1.
  - MemWriteE=1, RegWriteE=0, RD1=20, RD2=0xAABBCCDD, Imm=8 → ALU_ResultM=0x1C, WriteDataM=0xAABBCCDD, MemWriteM=1.
- BEQ:
  - Stimulus: op=001, BranchE=1, RD1=RD2=100, PCE=200, Imm=16.
  - Response, same cycle: PCSrcE=1, PCTargetE=216.
  - Changing RD2 to 101 → PCSrcE=0, PCTargetE still 216.
- Forwarding:
  - ForwardA=01, ResultW=0x12345678, RD2=1, op=000 → ALU_ResultM=0x12345679.
  - Next: ForwardA=00, ForwardB=10, RD1=2 → result = 2 + previous ALU_ResultM = 0x1234567B.
- ALU ops:
  - AND/OR of 0xF0F0F0F0 and 0x0FF00FF0 → 0x00F000F0 / 0xFFF0FFF0.
  - SLT with −1 vs 1 → 1.
  - Unused opcode 111 → 0 and Zero=1.
